// File: rtl/div32_seq_pkg.sv
// rtl/div32_seq_pkg.sv - shared multdiv constants, divider state encoding and sign helpers
package div32_seq_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // Datapath adder shared by abs and negate: a + b + carry-in.
    function automatic logic [DIV_WIDTH-1:0] f_add(
        input logic [DIV_WIDTH-1:0] a,
        input logic [DIV_WIDTH-1:0] b,
        input logic                 cin
    );
        return a + b + {{(DIV_WIDTH-1){1'b0}}, cin};
    endfunction

    function automatic logic [DIV_WIDTH-1:0] f_negate(input logic [DIV_WIDTH-1:0] x);
        return f_add({DIV_WIDTH{1'b0}}, ~x, 1'b1);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial subtract, select
module div_step
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // i_rem < |B| <= 2^(WIDTH-1), so the shifted value fits WIDTH bits and the
    // extra trial bit is a clean sign.
    assign w_shift = {i_rem, i_bit};
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign o_qbit  = ~w_trial[WIDTH];
    assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - sequential signed 32-bit restoring divider with start/ready handshake
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    div_state_t           r_state;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_divisor;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic                 r_div_zero;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH-1:0]     w_quo_neg;
    logic [WIDTH-1:0]     w_rem_neg;
    logic [WIDTH-1:0]     w_rem_next;
    logic                 w_qbit;

    assign w_abs_a   = data_operandA[WIDTH-1] ? f_negate(data_operandA) : data_operandA;
    assign w_abs_b   = data_operandB[WIDTH-1] ? f_negate(data_operandB) : data_operandB;
    assign w_quo_neg = f_negate(r_quo);
    assign w_rem_neg = f_negate(r_rem);

    // r_quo starts as |A| and fills with quotient bits as the dividend shifts out.
    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= DIV_IDLE;
            r_cnt          <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_divisor      <= '0;
            r_sign_a       <= 1'b0;
            r_sign_b       <= 1'b0;
            r_div_zero     <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                // A start in any state relatches and restarts; an aborted op never reports.
                r_state        <= DIV_RUN;
                r_cnt          <= '0;
                r_rem          <= '0;
                r_quo          <= w_abs_a;
                r_divisor      <= w_abs_b;
                r_sign_a       <= data_operandA[WIDTH-1];
                r_sign_b       <= data_operandB[WIDTH-1];
                r_div_zero     <= (data_operandB == '0);
                data_exception <= 1'b0;
            end else begin
                case (r_state)
                    DIV_IDLE: r_state <= DIV_IDLE;
                    DIV_RUN: begin
                        r_rem <= w_rem_next;
                        r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                        r_cnt <= r_cnt + DIV_CNT_W'(1);
                        if (r_cnt == DIV_CNT_W'(DIV_STEPS - 1)) begin
                            r_state <= DIV_FIX;
                        end
                    end
                    DIV_FIX: begin
                        if (r_div_zero) begin
                            data_result    <= '0;
                            data_remainder <= '0;
                        end else begin
                            data_result    <= (r_sign_a != r_sign_b) ? w_quo_neg : r_quo;
                            data_remainder <= r_sign_a ? w_rem_neg : r_rem;
                        end
                        data_exception <= r_div_zero;
                        data_resultRDY <= 1'b1;
                        r_state        <= DIV_DONE;
                    end
                    DIV_DONE: r_state <= DIV_IDLE;
                    default:  r_state <= DIV_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - randomized self-checking bench for div32_seq against an arithmetic model
module tb_div32_seq;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int          n_rdy;
    int          rdy_edge;
    logic [31:0] cap_q;
    logic [31:0] cap_r;
    logic        cap_e;

    div32_seq dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Signed division truncated toward zero, computed in 64 bits so -2^31/-1 cannot trap.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0; e = 1'b1;
        end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la - lq * lb;
            q = lq[31:0]; r = lr[31:0]; e = 1'b0;
        end
    endtask

    task automatic clear_cap();
        n_rdy = 0; rdy_edge = -1; cap_q = 'x; cap_r = 'x; cap_e = 1'bx;
    endtask

    // Called just after a negedge; returns t0 so that edge k is cyc == t0 + k.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int t0);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        t0            = cyc;
    endtask

    task automatic sample_until(input int t0, input int stop);
        while (cyc - t0 < stop) begin
            @(negedge clock);
            if (data_resultRDY) begin
                n_rdy++;
                if (n_rdy == 1) begin
                    rdy_edge = cyc - t0;
                    cap_q = data_result; cap_r = data_remainder; cap_e = data_exception;
                end
            end
        end
    endtask

    task automatic check_cap(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input int exp_edge);
        logic [31:0] q, r;
        logic        e;
        model(a, b, q, r, e);
        check({tag, "_rdy_count"}, 32'(n_rdy), 32'd1);
        check({tag, "_rdy_edge"}, 32'(rdy_edge), 32'(exp_edge));
        check({tag, "_quot"}, cap_q, q);
        check({tag, "_rem"}, cap_r, r);
        check({tag, "_exc"}, {31'd0, cap_e}, {31'd0, e});
    endtask

    task automatic expect_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int t0;
        clear_cap();
        start_op(a, b, t0);
        sample_until(t0, 35);
        check_cap(tag, a, b, 33);
    endtask

    initial begin
        int          t0, t1;
        logic [31:0] a, b;

        reset = 1'b1; ctrl_DIV = 1'b0; data_operandA = '0; data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_quot", data_result, 32'd0);
        check("reset_rem", data_remainder, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        expect_op("p100_7", 32'd100, 32'd7);
        check("p100_7_lit", cap_q, 32'd14);
        expect_op("n100_7", -32'sd100, 32'd7);
        check("n100_7_lit", cap_r, 32'hFFFF_FFFE);
        expect_op("p100_n7", 32'd100, -32'sd7);
        expect_op("div0", 32'd5, 32'd0);
        check("div0_lit", {31'd0, cap_e}, 32'd1);
        expect_op("after_div0", 32'd9, 32'd3);
        expect_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lit", cap_q, 32'h8000_0000);
        expect_op("min_by1", 32'h8000_0000, 32'd1);

        // Restart at edge 10: only the second op reports, 33 edges after it.
        clear_cap();
        start_op(32'd50, 32'd5, t0);
        sample_until(t0, 9);
        start_op(32'd81, 32'd9, t1);
        sample_until(t0, 46);
        check_cap("abort", 32'd81, 32'd9, 43);

        // Reset sampled at edge 15 discards the op and clears all outputs.
        clear_cap();
        start_op(32'd1000, 32'd3, t0);
        sample_until(t0, 14);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_quot", data_result, 32'd0);
        check("rst_mid_rem", data_remainder, 32'd0);
        check("rst_mid_exc", {31'd0, data_exception}, 32'd0);
        check("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        sample_until(t0, 60);
        check("rst_mid_no_rdy", 32'(n_rdy), 32'd0);
        expect_op("fresh_1000_3", 32'd1000, 32'd3);
        check("fresh_lit", cap_q, 32'd333);

        // Back-to-back: second start sampled at edge 34 while in DONE.
        clear_cap();
        start_op(32'd9, 32'd3, t0);
        sample_until(t0, 33);
        check_cap("b2b_first", 32'd9, 32'd3, 33);
        clear_cap();
        start_op(-32'sd200, 32'd9, t1);
        check("b2b_start_edge", 32'(t1 - t0), 32'd34);
        sample_until(t1, 35);
        check_cap("b2b_second", -32'sd200, 32'd9, 33);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($signed($urandom_range(0, 40)) - 20);
                2:       b = $urandom;
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            expect_op($sformatf("rand%0d", i), a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
